cpu_run_ctrl: RTL and testbench

- Run/reset sequencer for the 6502 core. Replaces free-running slow-clock and reset-pulse generation with a single-clock-domain controller.
- Drives a one-cycle clock enable (cpu_ce) and a CPU reset (cpu_res) to the core.
- Supports power-on reset hold, run, halt, single-step and periodic auto-restart.
- Sits between the board clock/buttons and the cpu instance. The core is clocked on CLK and gated by cpu_ce.

---
 rtl/cpu_run_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/reset sequencer for the 6502 core: divided clock enable, reset hold, run/halt/step, auto-restart.
// Define RUN_CTRL_SYNC_EN to add input synchronizers and halt/step edge detection.
module cpu_run_ctrl #(
  parameter int unsigned DIV           = 6000000,
  parameter int unsigned RST_CYCLES    = 2,
  parameter int unsigned RESTART_TICKS = 50
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       run_req,
  input  logic       halt_req,
  input  logic       step_req,
  output logic       cpu_ce,
  output logic       cpu_res,
  output logic [1:0] state,
  output logic [7:0] tick_cnt
);

  localparam int unsigned DIV_W        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned RST_W        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam bit          RESTART_EN   = (RESTART_TICKS != 0);
  localparam logic [31:0] RESTART_LAST = RESTART_EN ? 32'(RESTART_TICKS - 1) : 32'd0;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_STEP  = 2'd3
  } state_t;

  state_t           state_q, state_n;
  logic [DIV_W-1:0] div_cnt;
  logic [RST_W-1:0] rst_cnt, rst_cnt_n;
  logic [31:0]      run_cnt, run_cnt_n;
  logic             halt_p, halt_n, step_p, step_n;
  logic             run_in, halt_in, step_in;
  logic             halt_pend, step_pend;
  logic             wrap, tick;

`ifdef RUN_CTRL_SYNC_EN
  // Two-flop synchronizers; halt/step get a registered rising-edge pulse.
  logic [2:0] halt_sync, step_sync;
  logic [1:0] run_sync;
  logic       halt_edge, step_edge;

  always_ff @(posedge CLK) begin
    if (R) begin
      run_sync  <= 2'b00;
      halt_sync <= 3'b000;
      step_sync <= 3'b000;
      halt_edge <= 1'b0;
      step_edge <= 1'b0;
    end else begin
      run_sync  <= {run_sync[0], run_req};
      halt_sync <= {halt_sync[1:0], halt_req};
      step_sync <= {step_sync[1:0], step_req};
      halt_edge <= halt_sync[1] & ~halt_sync[2];
      step_edge <= step_sync[1] & ~step_sync[2];
    end
  end

  assign run_in  = run_sync[1];
  assign halt_in = halt_edge;
  assign step_in = step_edge;
`else
  assign run_in  = run_req;
  assign halt_in = halt_req;
  assign step_in = step_req;
`endif

  assign wrap      = (div_cnt == DIV_LAST);
  assign halt_pend = halt_p | halt_in;
  assign step_pend = step_p | step_in;
  assign state     = state_q;
  assign tick_cnt  = run_cnt[7:0];

  // Next state and counters; everything except request latching moves only on wrap cycles.
  always_comb begin
    state_n   = state_q;
    rst_cnt_n = rst_cnt;
    run_cnt_n = run_cnt;
    halt_n    = halt_pend;
    step_n    = step_pend;
    tick      = 1'b0;
    if (wrap) begin
      unique case (state_q)
        ST_RESET: begin
          tick = 1'b1;
          if (rst_cnt == RST_LAST) begin
            rst_cnt_n = '0;
            run_cnt_n = 32'd0;
            state_n   = run_in ? ST_RUN : ST_HALT;
          end else begin
            rst_cnt_n = rst_cnt + RST_W'(1);
          end
        end
        ST_RUN: begin
          if (halt_pend || !run_in) begin
            halt_n  = 1'b0;
            state_n = ST_HALT;
          end else begin
            tick      = 1'b1;
            run_cnt_n = run_cnt + 32'd1;
            if (RESTART_EN && (run_cnt == RESTART_LAST)) begin
              run_cnt_n = 32'd0;
              state_n   = ST_RESET;
            end
          end
        end
        ST_HALT: begin
          if (step_pend) begin
            step_n  = 1'b0;
            state_n = ST_STEP;
          end else if (run_in && !halt_pend) begin
            state_n = ST_RUN;
          end else begin
            halt_n = 1'b0;
          end
        end
        ST_STEP: begin
          tick      = 1'b1;
          run_cnt_n = run_cnt + 32'd1;
          if (RESTART_EN && (run_cnt == RESTART_LAST)) begin
            run_cnt_n = 32'd0;
            state_n   = ST_RESET;
          end else begin
            state_n = ST_HALT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      div_cnt <= '0;
      state_q <= ST_RESET;
      rst_cnt <= '0;
      run_cnt <= 32'd0;
      halt_p  <= 1'b0;
      step_p  <= 1'b0;
      cpu_ce  <= 1'b0;
      cpu_res <= 1'b1;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + DIV_W'(1);
      state_q <= state_n;
      rst_cnt <= rst_cnt_n;
      run_cnt <= run_cnt_n;
      halt_p  <= halt_n;
      step_p  <= step_n;
      cpu_ce  <= wrap & tick;
      if (wrap) begin
        cpu_res <= (state_q == ST_RESET);
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: expected cpu_ce pulses are queued by stimulus, popped by a monitor.
module tb_cpu_run_ctrl;

  logic       CLK = 1'b0;
  logic       R, run_req, halt_req, step_req;
  logic       cpu_ce, cpu_res, cpu_ce_b, cpu_res_b;
  logic [1:0] state, state_b;
  logic [7:0] tick_cnt, tick_cnt_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct packed {
    logic [15:0] cyc;
    logic        res;
    logic [1:0]  st;
    logic [7:0]  tick;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_got, mon_exp;

  always #5 CLK = ~CLK;

  cpu_run_ctrl #(.DIV(4), .RST_CYCLES(2), .RESTART_TICKS(5)) dut (
    .CLK(CLK), .R(R), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .cpu_ce(cpu_ce), .cpu_res(cpu_res), .state(state), .tick_cnt(tick_cnt)
  );

  cpu_run_ctrl #(.DIV(4), .RST_CYCLES(2), .RESTART_TICKS(0)) dut_nr (
    .CLK(CLK), .R(R), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .cpu_ce(cpu_ce_b), .cpu_res(cpu_res_b), .state(state_b), .tick_cnt(tick_cnt_b)
  );

  // Monitor: every cpu_ce pulse must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (mon_en && (cpu_ce === 1'b1)) begin
      checks++;
      mon_got = {16'(cyc), cpu_res, state, tick_cnt};
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL ce_pulse: unexpected cpu_ce at cycle %0d res=%0b state=%0d tick=%0d",
                 cyc, cpu_res, state, tick_cnt);
      end else begin
        mon_exp = sb_q.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL ce_pulse: got cyc=%0d res=%0b state=%0d tick=%0d, expected cyc=%0d res=%0b state=%0d tick=%0d",
                   mon_got.cyc, mon_got.res, mon_got.st, mon_got.tick,
                   mon_exp.cyc, mon_exp.res, mon_exp.st, mon_exp.tick);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick_clk();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick_clk();
  endtask

  task automatic expect_ce(input int c, input logic res, input logic [1:0] st, input logic [7:0] t);
    exp_t e;
    e = {16'(c), res, st, t};
    sb_q.push_back(e);
  endtask

  task automatic apply_reset();
    R = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    R   = 1'b0;
    cyc = 0;
  endtask

  task automatic drain_check(input string name);
    check(name, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    int errs;
    int exp_tick;
    logic exp_ce;
    logic [1:0] exp_st;

    R = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_ce", cpu_ce, 0);
    check("reset_res", cpu_res, 1);
    check("reset_state", state, 0);
    check("reset_tick", tick_cnt, 0);

    // Reset sequence, run, auto-restart after 5 run ticks.
    mon_en  = 1'b1;
    run_req = 1'b1;
    expect_ce(4, 1, 0, 0);  expect_ce(8, 1, 1, 0);  expect_ce(12, 0, 1, 1);
    expect_ce(16, 0, 1, 2); expect_ce(20, 0, 1, 3); expect_ce(24, 0, 1, 4);
    expect_ce(28, 0, 0, 0); expect_ce(32, 1, 0, 0); expect_ce(36, 1, 1, 0);
    expect_ce(40, 0, 1, 1);
    apply_reset();
    run_to(27);
    check("run_state_pre_restart", state, 1);
    run_to(28);
    check("restart_state", state, 0);
    run_to(39);
    check("restart_tick_clear", tick_cnt, 0);
    run_to(41);
    drain_check("restart_pulses_all_seen");

    // Halt request pulse while running; run_req dropped once halted.
    run_req = 1'b1;
    expect_ce(4, 1, 0, 0); expect_ce(8, 1, 1, 0); expect_ce(12, 0, 1, 1);
    apply_reset();
    run_to(13);
    halt_req = 1'b1;
    tick_clk();
    halt_req = 1'b0;
    run_to(15);
    check("halt_state_before_wrap", state, 1);
    run_to(16);
    check("halt_state", state, 2);
    run_req = 1'b0;
    run_to(40);
    check("halt_state_held", state, 2);
    check("halt_tick_held", tick_cnt, 1);
    drain_check("halt_pulses_all_seen");

    // Single step from HALT.
    run_req = 1'b0;
    expect_ce(4, 1, 0, 0); expect_ce(8, 1, 2, 0); expect_ce(24, 0, 2, 1);
    apply_reset();
    run_to(17);
    step_req = 1'b1;
    tick_clk();
    step_req = 1'b0;
    run_to(19);
    check("step_pre_state", state, 2);
    run_to(20);
    check("step_state", state, 3);
    run_to(24);
    check("step_back_halt", state, 2);
    check("step_tick", tick_cnt, 1);
    run_to(40);
    check("step_tick_held", tick_cnt, 1);
    drain_check("step_pulses_all_seen");

    // Reset asserted mid-run for one cycle.
    run_req = 1'b1;
    expect_ce(4, 1, 0, 0); expect_ce(8, 1, 1, 0); expect_ce(12, 0, 1, 1);
    apply_reset();
    run_to(14);
    R = 1'b1;
    tick_clk();
    check("midrst_ce", cpu_ce, 0);
    check("midrst_res", cpu_res, 1);
    check("midrst_state", state, 0);
    check("midrst_tick", tick_cnt, 0);
    drain_check("midrst_pre_pulses");
    expect_ce(4, 1, 0, 0); expect_ce(8, 1, 1, 0);
    R   = 1'b0;
    cyc = 0;
    run_to(10);
    drain_check("midrst_restart_pulses");

    // Auto-restart disabled: free run for 2000 cycles, tick_cnt wraps.
    mon_en  = 1'b0;
    run_req = 1'b1;
    errs    = 0;
    apply_reset();
    while (cyc < 2000) begin
      tick_clk();
      exp_ce   = (cyc >= 4) && (cyc % 4 == 0);
      exp_st   = (cyc >= 8) ? 2'd1 : 2'd0;
      exp_tick = (cyc >= 8) ? (((cyc - 8) / 4) % 256) : 0;
      if ((cpu_ce_b !== exp_ce) || (state_b !== exp_st) || (tick_cnt_b !== 8'(exp_tick))) begin
        if (errs == 0)
          $display("FAIL rt0_track: cycle %0d got ce=%0b state=%0d tick=%0d expected ce=%0b state=%0d tick=%0d",
                   cyc, cpu_ce_b, state_b, tick_cnt_b, exp_ce, exp_st, exp_tick);
        errs++;
      end
      if (cyc == 1031) check("rt0_tick_255", tick_cnt_b, 255);
      if (cyc == 1032) check("rt0_tick_wrap", tick_cnt_b, 0);
    end
    check("rt0_track_errors", errs, 0);
    check("rt0_final_state", state_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
